// File: rtl/fifo_drain_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  fifo_drain_buffer_pkg
//  Shared state encoding and default sizing for the FIFO drain buffer.
//  Revision: 1.0
// ============================================================================
package fifo_drain_buffer_pkg;

    localparam int C_DATA_W = 8;
    localparam int C_DEPTH  = 16;
    localparam int C_ADDR_W = 4;
    localparam int C_SUM_W  = C_DATA_W + C_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

endpackage : fifo_drain_buffer_pkg
`default_nettype wire

// File: rtl/fifo_drain_buffer_ram.sv
`default_nettype none
// ============================================================================
//  drain_buf_ram
//  DEPTH x DATA_W register array: synchronous write, combinational read,
//  asynchronous clear.
//  Revision: 1.0
// ============================================================================
module drain_buf_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-during-write returns the pre-edge contents.
    assign rdata_o = mem_q[raddr_i];

endmodule : drain_buf_ram
`default_nettype wire

// File: rtl/fifo_drain_buffer.sv
`default_nettype none
// ============================================================================
//  fifo_drain_buffer
//  Pops a DEPTH-byte burst from the read side of a FIFO into a local buffer,
//  summing the bytes, and flags done; buffer is readable combinationally.
//  Revision: 1.0
// ============================================================================
module fifo_drain_buffer
    import fifo_drain_buffer_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int DEPTH  = C_DEPTH,
    parameter int ADDR_W = C_ADDR_W,
    parameter int SUM_W  = C_SUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rempty,
    input  logic [DATA_W-1:0] rdata,
    output logic              rinc,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [SUM_W-1:0]  sum,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done
);

    localparam int unsigned   C_LAST_I  = DEPTH - 1;
    localparam logic [ADDR_W:0]   C_LAST    = C_LAST_I[ADDR_W:0];
    localparam logic [ADDR_W:0]   C_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    drain_state_e      state_q;
    logic [SUM_W-1:0]  sum_q;
    logic [SUM_W-1:0]  sum_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] wptr_d;
    logic              busy_q;
    logic              done_q;
    logic              last_pop;

    // Never pop an empty FIFO; reset drops this immediately via state_q.
    assign rinc     = (state_q == DRAIN) && !rempty;

    assign sum_d    = sum_q + {{(SUM_W-DATA_W){1'b0}}, rdata};
    assign count_d  = count_q + C_CNT_ONE;
    assign wptr_d   = wptr_q + C_PTR_ONE;
    assign last_pop = rinc && (count_q == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            count_q <= '0;
            wptr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= DRAIN;
                        sum_q   <= '0;
                        count_q <= '0;
                        wptr_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // start is deliberately not examined here.
                    if (rinc) begin
                        sum_q   <= sum_d;
                        count_q <= count_d;
                        wptr_q  <= wptr_d;
                        if (last_pop) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    drain_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (rinc),
        .waddr_i (wptr_q),
        .wdata_i (rdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign sum   = sum_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule : fifo_drain_buffer
`default_nettype wire

// File: tb/tb_fifo_drain_buffer.sv
`default_nettype none
// ============================================================================
//  tb_fifo_drain_buffer
//  Randomized scoreboard bench: a queue-based FIFO model feeds the DUT and a
//  monitor checks each burst result and snapshot against expected values.
//  Revision: 1.0
// ============================================================================
module tb_fifo_drain_buffer;

    localparam int K_SNAP  = 0;
    localparam int K_BURST = 1;

    typedef struct {
        int           kind;
        string        name;
        int           sum;
        int           count;
        int           busy;
        int           done;
        int           rinc;
        int           lat;
        int           gap_count;
        int           fifo_left;
        logic [127:0] mem;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [11:0] sum;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    exp_t        exp_q [$];
    logic [7:0]  fifo_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    bit          force_empty;
    bit          bubbles;
    bit          mon_busy;

    logic [7:0]  full_burst [16] = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
                                     8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};

    always #50 clk = ~clk;

    fifo_drain_buffer #(
        .DATA_W (8),
        .DEPTH  (16),
        .ADDR_W (4),
        .SUM_W  (12)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .sum     (sum),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int sum_of(input logic [127:0] d);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(d[i*8 +: 8]);
        return s;
    endfunction

    function automatic logic [127:0] rand_data();
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // ---------------- FIFO model and stimulus helpers ----------------
    task automatic drive_fifo();
        rempty = force_empty || (fifo_q.size() == 0);
        rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic tick();
        bit pop;
        @(negedge clk);
        pop = rinc;
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (bubbles) force_empty = ($urandom_range(0, 3) == 0);
        drive_fifo();
    endtask

    task automatic push_words(input logic [127:0] d, input int n, input int from);
        for (int i = from; i < from + n; i++) fifo_q.push_back(d[i*8 +: 8]);
        drive_fifo();
    endtask

    task automatic push_snap(input string name, input int s, input int c, input int b,
                             input int dn, input int ri, input int left, input logic [127:0] m);
        exp_t e;
        e.kind = K_SNAP; e.name = name; e.sum = s; e.count = c; e.busy = b; e.done = dn;
        e.rinc = ri; e.lat = -1; e.gap_count = -1; e.fifo_left = left; e.mem = m;
        exp_q.push_back(e);
    endtask

    task automatic start_burst(input string name, input logic [127:0] d, input int lat, input int gap);
        exp_t e;
        e.kind = K_BURST; e.name = name; e.sum = sum_of(d); e.count = 16; e.busy = 0; e.done = 1;
        e.rinc = 0; e.lat = lat; e.gap_count = gap; e.fifo_left = -1; e.mem = d;
        pops  = 0;
        start = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pops < target && n < 200) begin
            tick();
            n++;
        end
        chk("wait_pops_reached", 32'(pops), 32'(target));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick();
            n++;
        end while ((exp_q.size() > 0 || mon_busy) && n < 2000);
        if (n >= 2000) chk("monitor_idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    task automatic safety();
        if (rempty) chk("rinc_while_empty", 32'(rinc), 32'd0);
    endtask

    task automatic compare(input exp_t e);
        chk({e.name, "_sum"},   32'(sum),   32'(e.sum));
        chk({e.name, "_count"}, 32'(count), 32'(e.count));
        chk({e.name, "_busy"},  32'(busy),  32'(e.busy));
        chk({e.name, "_done"},  32'(done),  32'(e.done));
        chk({e.name, "_rinc"},  32'(rinc),  32'(e.rinc));
        if (e.fifo_left >= 0) chk({e.name, "_fifo_left"}, 32'(fifo_q.size()), 32'(e.fifo_left));
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            chk($sformatf("%s_buf[%0d]", e.name, i), 32'(rd_data), 32'(e.mem[i*8 +: 8]));
        end
    endtask

    initial begin
        exp_t e;
        int   k;
        int   npop;
        rd_addr  = '0;
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            safety();
            if (exp_q.size() > 0) begin
                mon_busy = 1'b1;
                e = exp_q.pop_front();
                if (e.kind == K_SNAP) begin
                    compare(e);
                end else begin
                    // This negedge precedes the edge that captures start.
                    k    = 1;
                    npop = 0;
                    while (!(k > 1 && done) && k < 400) begin
                        @(negedge clk);
                        k++;
                        safety();
                        if (rinc) npop++;
                        if (e.gap_count >= 0 && rempty && !done) begin
                            chk({e.name, "_stall_busy"},  32'(busy),  32'd1);
                            chk({e.name, "_stall_count"}, 32'(count), 32'(e.gap_count));
                        end
                    end
                    chk({e.name, "_done_seen"}, 32'(done), 32'd1);
                    if (e.lat >= 0) chk({e.name, "_latency"}, 32'(k - 1), 32'(e.lat));
                    chk({e.name, "_pops"}, 32'(npop), 32'd16);
                    compare(e);
                end
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] d;
        rst = 1'b1; start = 1'b0; force_empty = 1'b0; bubbles = 1'b0;
        drive_fifo();
        repeat (3) tick();
        rst = 1'b0;
        push_snap("reset", 0, 0, 0, 0, 0, -1, '0);
        wait_idle();

        for (int i = 0; i < 16; i++) d[i*8 +: 8] = full_burst[i];
        push_words(d, 16, 0);
        tick();
        start_burst("full", d, 17, -1);
        wait_idle();

        d = rand_data();
        push_words(d, 5, 0);
        start_burst("stall", d, -1, 5);
        repeat (40) tick();
        push_words(d, 11, 5);
        wait_idle();

        d = '1;
        push_words(d, 16, 0);
        start_burst("all_ff", d, 17, -1);
        wait_idle();

        d = rand_data();
        push_words(d, 16, 0);
        start_burst("ign_start", d, 17, -1);
        wait_pops(7);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();

        // Two spare words reveal a wrongly accepted start on the final pop.
        d = rand_data();
        push_words(d, 16, 0);
        push_words(rand_data(), 2, 0);
        start_burst("coincide", d, 17, -1);
        wait_pops(15);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (3) tick();
        push_snap("coincide_after", sum_of(d), 16, 0, 1, 0, 2, d);
        wait_idle();

        force_empty = 1'b1;
        drive_fifo();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        push_snap("empty_guard", 0, 0, 1, 0, 0, 2, d);
        wait_idle();

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        fifo_q.delete();
        force_empty = 1'b0;
        drive_fifo();
        tick();

        for (int r = 0; r < 3; r++) begin
            d = rand_data();
            push_words(d, 16, 0);
            bubbles = 1'b1;
            start_burst($sformatf("bubble%0d", r), d, -1, -1);
            wait_idle();
            bubbles = 1'b0;
            force_empty = 1'b0;
            drive_fifo();
        end

        d = rand_data();
        push_words(d, 16, 0);
        pops  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pops(9);
        rst = 1'b1;
        push_snap("mid_reset", 0, 0, 0, 0, 0, 7, '0);
        wait_idle();
        rst = 1'b0;
        repeat (3) tick();
        push_snap("after_reset", 0, 0, 0, 0, 0, 7, '0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_fifo_drain_buffer
`default_nettype wire
